// File: rtl/bus_mux_pkg.sv
// Shared types and helpers for the bus master mux.
// The helpers work on a fixed-width vector so any MASTERS up to MAX_MASTERS can use them.
package bus_mux_pkg;

  localparam int MAX_MASTERS = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } bus_state_t;

  // Keeps only the lowest set bit, so an arbiter fault cannot select two owners.
  function automatic logic [MAX_MASTERS-1:0] onehot_lsb(input logic [MAX_MASTERS-1:0] vec);
    return vec & (~vec + MAX_MASTERS'(1));
  endfunction

  function automatic int unsigned onehot_to_index(input logic [MAX_MASTERS-1:0] vec);
    int unsigned idx = 0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_master_mux_if.sv
// Master-side request bundles and the shared slave bus of the bus master mux.
// The master modport is the mux view; the slave modport is the surrounding environment.
interface bus_master_mux_if #(
  parameter int MASTERS = 4,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 8
);
  logic [MASTERS-1:0]        m_req_i;
  logic [MASTERS-1:0]        grant_i;
  logic [MASTERS-1:0]        m_we_i;
  logic [MASTERS*ADDR_W-1:0] m_addr_i;
  logic [MASTERS*DATA_W-1:0] m_wdata_i;
  logic [MASTERS-1:0]        m_ack_o;
  logic [MASTERS-1:0]        m_err_o;
  logic [DATA_W-1:0]         m_rdata_o;
  logic                      s_stb_o;
  logic                      s_we_o;
  logic [ADDR_W-1:0]         s_addr_o;
  logic [DATA_W-1:0]         s_wdata_o;
  logic                      s_ack_i;
  logic [DATA_W-1:0]         s_rdata_i;
  logic                      busy_o;

  modport master (
    input  m_req_i, grant_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    output m_ack_o, m_err_o, m_rdata_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o, busy_o
  );

  modport slave (
    output m_req_i, grant_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    input  m_ack_o, m_err_o, m_rdata_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o, busy_o
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// Saturating strobe-cycle counter; expired_o flags the last cycle before a timeout.
// TIMEOUT of 0 keeps expired_o low forever.
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/bus_master_mux.sv
// Locks the granted, requesting master as owner and runs one strobe/ack transfer on the
// shared slave bus, returning a one-cycle ack or timeout error to that owner.
//
// state   | meaning
// IDLE    | waiting for a master that is both granted and requesting
// ACTIVE  | strobe held to the slave until ack or timeout
// RELEASE | one-cycle ack/err pulse, owner cleared, arbiter may re-grant
module bus_master_mux
  import bus_mux_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input logic              clk_i,
  input logic              reset_i,
  bus_master_mux_if.master bus
);

  bus_state_t          state_q, state_d;
  logic [MASTERS-1:0]  owner_q, owner_d;
  logic [MASTERS-1:0]  ack_q, ack_d, err_q, err_d;
  logic [MASTERS-1:0]  cand, cand_oh;
  logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d, wdata_sel;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_sel;
  logic                stb_q, stb_d, we_q, we_d, we_sel, busy_q;
  logic                accept, expired;
  int unsigned         idx;

  always_comb begin
    cand      = bus.grant_i & bus.m_req_i;
    cand_oh   = MASTERS'(onehot_lsb(MAX_MASTERS'(cand)));
    idx       = onehot_to_index(MAX_MASTERS'(cand_oh));
    we_sel    = 1'(bus.m_we_i >> idx);
    addr_sel  = ADDR_W'(bus.m_addr_i >> (idx * ADDR_W));
    wdata_sel = DATA_W'(bus.m_wdata_i >> (idx * DATA_W));
  end

  assign accept = (state_q == IDLE) && (cand != '0);

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (accept),
    .enable_i (state_q == ACTIVE),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE:  if (bus.s_ack_i || expired) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; ack takes priority over a same-cycle timeout.
  always_comb begin
    owner_d = owner_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = cand_oh;
          stb_d   = 1'b1;
          we_d    = we_sel;
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
        end
      end
      ACTIVE: begin
        if (bus.s_ack_i) begin
          ack_d   = owner_q;
          rdata_d = bus.s_rdata_i;
          stb_d   = 1'b0;
        end else if (expired) begin
          err_d = owner_q;
          stb_d = 1'b0;
        end
      end
      RELEASE: owner_d = '0;
      default: owner_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.m_ack_o   = ack_q;
  assign bus.m_err_o   = err_q;
  assign bus.m_rdata_o = rdata_q;
  assign bus.s_stb_o   = stb_q;
  assign bus.s_we_o    = we_q;
  assign bus.s_addr_o  = addr_q;
  assign bus.s_wdata_o = wdata_q;
  assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_bus_master_mux.sv
// Transaction-level bench for bus_master_mux: each transfer's owner, slave fields, strobe
// length and completion pulse are predicted from the arbitration and handshake rules.
module tb_bus_master_mux;

  localparam int MASTERS = 4;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 4;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  bus_master_mux_if #(.MASTERS(MASTERS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_master_mux #(.MASTERS(MASTERS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] addr_m[MASTERS];
  logic [DATA_W-1:0] wdata_m[MASTERS];
  logic              we_m[MASTERS];
  logic [DATA_W-1:0] last_rdata;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_masters();
    for (int i = 0; i < MASTERS; i++) begin
      bus.m_addr_i[i*ADDR_W +: ADDR_W]  = addr_m[i];
      bus.m_wdata_i[i*DATA_W +: DATA_W] = wdata_m[i];
      bus.m_we_i[i]                     = we_m[i];
    end
  endtask

  task automatic randomize_masters();
    for (int i = 0; i < MASTERS; i++) begin
      addr_m[i]  = ADDR_W'($urandom);
      wdata_m[i] = DATA_W'($urandom);
      we_m[i]    = 1'($urandom);
    end
    drive_masters();
  endtask

  // One transfer starting in IDLE. ack_on = strobe cycle carrying s_ack_i (> TIMEOUT: never).
  // mode 0: inputs steady, 1: random disturbance during ACTIVE, 2: preemption to master 0.
  task automatic do_txn(input logic [3:0] gnt, input logic [3:0] req, input int ack_on,
                        input logic [7:0] rd, input int mode, input string tag);
    int own;
    logic [3:0] cand;
    logic [3:0] own_oh;
    logic [3:0] exp_ack;
    logic [3:0] exp_err;
    own  = -1;
    cand = gnt & req;
    for (int i = MASTERS - 1; i >= 0; i--) if (cand[i]) own = i;
    bus.grant_i = gnt;
    bus.m_req_i = req;
    bus.s_ack_i = 1'b0;
    tick();
    if (own < 0) begin
      checks++;
      if (bus.busy_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
        failures++;
        $display("FAIL %s no_accept: busy=%b stb=%b required busy=0 stb=0", tag, bus.busy_o, bus.s_stb_o);
      end
      bus.grant_i = '0;
      bus.m_req_i = '0;
      return;
    end
    own_oh = 4'b0001 << own;
    for (int s = 1; s <= TIMEOUT; s++) begin
      checks++;
      if (bus.s_stb_o !== 1'b1 || bus.s_addr_o !== addr_m[own] || bus.s_we_o !== we_m[own] ||
          bus.s_wdata_o !== wdata_m[own] || bus.busy_o !== 1'b1 || bus.m_ack_o !== 4'b0 ||
          bus.m_err_o !== 4'b0) begin
        failures++;
        $display("FAIL %s strobe%0d: stb=%b addr=%h we=%b wdata=%h busy=%b ack=%b err=%b required stb=1 addr=%h we=%b wdata=%h busy=1 ack=0 err=0",
                 tag, s, bus.s_stb_o, bus.s_addr_o, bus.s_we_o, bus.s_wdata_o, bus.busy_o,
                 bus.m_ack_o, bus.m_err_o, addr_m[own], we_m[own], wdata_m[own]);
      end
      if (mode == 1) begin
        bus.grant_i   = 4'($urandom);
        bus.m_req_i   = 4'($urandom);
        bus.m_we_i    = 4'($urandom);
        bus.m_addr_i  = {$urandom, $urandom, $urandom};
        bus.m_wdata_i = 32'($urandom);
      end else if (mode == 2) begin
        bus.grant_i = 4'b0001;
        bus.m_req_i = 4'b1001;
      end
      bus.s_ack_i   = (s == ack_on);
      bus.s_rdata_i = (s == ack_on) ? rd : DATA_W'($urandom);
      tick();
      if (s == ack_on) break;
    end
    exp_ack = (ack_on <= TIMEOUT) ? own_oh : 4'b0;
    exp_err = (ack_on <= TIMEOUT) ? 4'b0 : own_oh;
    if (ack_on <= TIMEOUT) last_rdata = rd;
    checks++;
    if (bus.m_ack_o !== exp_ack || bus.m_err_o !== exp_err || bus.m_rdata_o !== last_rdata ||
        bus.s_stb_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL %s release: ack=%b err=%b rdata=%h stb=%b busy=%b required ack=%b err=%b rdata=%h stb=0 busy=1",
               tag, bus.m_ack_o, bus.m_err_o, bus.m_rdata_o, bus.s_stb_o, bus.busy_o,
               exp_ack, exp_err, last_rdata);
    end
    bus.grant_i   = '0;
    bus.m_req_i   = '0;
    drive_masters();
    bus.s_ack_i   = (ack_on > TIMEOUT) ? 1'b1 : 1'($urandom);
    bus.s_rdata_i = DATA_W'($urandom);
    tick();
    checks++;
    if (bus.busy_o !== 1'b0 || bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0 ||
        bus.s_stb_o !== 1'b0 || bus.m_rdata_o !== last_rdata) begin
      failures++;
      $display("FAIL %s idle: busy=%b ack=%b err=%b stb=%b rdata=%h required busy=0 ack=0 err=0 stb=0 rdata=%h",
               tag, bus.busy_o, bus.m_ack_o, bus.m_err_o, bus.s_stb_o, bus.m_rdata_o, last_rdata);
    end
    bus.s_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    bus.grant_i = '0; bus.m_req_i = '0; bus.s_ack_i = 1'b0; bus.s_rdata_i = '0;
    for (int i = 0; i < MASTERS; i++) begin
      addr_m[i] = '0; wdata_m[i] = '0; we_m[i] = 1'b0;
    end
    drive_masters();
    tick(); tick();
    reset_i = 1'b0;
    last_rdata = '0;
    checks++;
    if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0 || bus.m_rdata_o !== 8'h00 ||
        bus.s_stb_o !== 1'b0 || bus.s_we_o !== 1'b0 || bus.s_addr_o !== 24'h0 ||
        bus.s_wdata_o !== 8'h00 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset: ack=%b err=%b rdata=%h stb=%b we=%b addr=%h wdata=%h busy=%b required all zero",
               bus.m_ack_o, bus.m_err_o, bus.m_rdata_o, bus.s_stb_o, bus.s_we_o, bus.s_addr_o,
               bus.s_wdata_o, bus.busy_o);
    end
  endtask

  task automatic test_read_wait();
    addr_m[0] = 24'h00FFFC; we_m[0] = 1'b0; wdata_m[0] = 8'h11;
    drive_masters();
    do_txn(4'b0001, 4'b0001, 2, 8'hA5, 0, "read_wait");
  endtask

  task automatic test_write_zero_wait();
    addr_m[2] = 24'h012345; we_m[2] = 1'b1; wdata_m[2] = 8'h3C;
    drive_masters();
    do_txn(4'b0100, 4'b0100, 1, 8'h77, 0, "write_zero_wait");
  endtask

  task automatic test_no_request();
    do_txn(4'b0010, 4'b0001, 1, 8'h00, 0, "grant_no_req");
  endtask

  task automatic test_preempt();
    addr_m[3] = 24'hABCDEF; we_m[3] = 1'b1; wdata_m[3] = 8'h5A;
    addr_m[0] = 24'h000100; we_m[0] = 1'b0;
    drive_masters();
    do_txn(4'b1000, 4'b1000, 3, 8'hC3, 2, "preempt_owner");
    do_txn(4'b0001, 4'b0001, 1, 8'h3E, 0, "preempt_next");
  endtask

  task automatic test_timeout();
    addr_m[1] = 24'h0BEEF0; we_m[1] = 1'b0;
    drive_masters();
    do_txn(4'b0010, 4'b0010, TIMEOUT + 1, 8'hFF, 0, "timeout");
    bus.s_ack_i = 1'b1;
    tick();
    checks++;
    if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL late_ack: ack=%b err=%b busy=%b required 0 0 0", bus.m_ack_o, bus.m_err_o, bus.busy_o);
    end
    bus.s_ack_i = 1'b0;
  endtask

  task automatic test_ack_at_limit();
    do_txn(4'b0100, 4'b0100, TIMEOUT, 8'h69, 0, "ack_at_limit");
  endtask

  task automatic test_multi_hot();
    do_txn(4'b1110, 4'b1010, 1, 8'h4D, 0, "multi_hot");
  endtask

  task automatic test_reset_mid();
    addr_m[1] = 24'h123456; we_m[1] = 1'b1; wdata_m[1] = 8'h99;
    drive_masters();
    bus.grant_i = 4'b0010; bus.m_req_i = 4'b0010;
    tick();
    checks++;
    if (bus.s_stb_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_start: stb=%b required 1", bus.s_stb_o);
    end
    tick();
    reset_i = 1'b1; bus.s_ack_i = 1'b1; bus.s_rdata_i = 8'hEE;
    tick();
    last_rdata = '0;
    checks++;
    if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0 || bus.m_rdata_o !== 8'h00 ||
        bus.s_stb_o !== 1'b0 || bus.s_we_o !== 1'b0 || bus.s_addr_o !== 24'h0 ||
        bus.s_wdata_o !== 8'h00 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: ack=%b err=%b rdata=%h stb=%b we=%b addr=%h wdata=%h busy=%b required all zero",
               bus.m_ack_o, bus.m_err_o, bus.m_rdata_o, bus.s_stb_o, bus.s_we_o, bus.s_addr_o,
               bus.s_wdata_o, bus.busy_o);
    end
    reset_i = 1'b0; bus.s_ack_i = 1'b0; bus.grant_i = '0; bus.m_req_i = '0;
    tick();
    checks++;
    if (bus.m_ack_o !== 4'b0 || bus.m_err_o !== 4'b0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after: ack=%b err=%b busy=%b required 0 0 0", bus.m_ack_o, bus.m_err_o, bus.busy_o);
    end
    do_txn(4'b0010, 4'b0010, 1, 8'h42, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      randomize_masters();
      do_txn(4'($urandom), 4'($urandom), int'($urandom_range(1, TIMEOUT + 2)),
             DATA_W'($urandom), int'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_write_zero_wait();
    test_no_request();
    test_preempt();
    test_timeout();
    test_ack_at_limit();
    test_multi_hot();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
